// File: rtl/i2c_regbank.sv
// i2c_regbank: register bank behind the I2C slave application bus.
// Holds the device ID, CTRL, a sticky interrupt block (status/mask), GPO,
// synchronized GPI, a saturating write counter and 8 bytes of scratch.
//
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   rw, addr, wen,    slave application bus (rw=1 read, wen one-cycle
//   wdata, rdata_used write strobe, rdata_used one-cycle capture pulse
//                     issued after addr has already incremented)
//   rdata             registered read data for the current addr
//   irq_in            asynchronous rising-edge interrupt sources
//   gpi               asynchronous general-purpose inputs
//   ctrl, gpo         register outputs
//   irq               registered |(status & mask)
module i2c_regbank #(
    parameter logic [7:0] DEVICE_ID  = 8'hA5,
    parameter logic [7:0] CTRL_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic       wen,
    input  logic [7:0] wdata,
    input  logic       rdata_used,
    output logic [7:0] rdata,
    input  logic [6:0] irq_in,
    input  logic [7:0] gpi,
    output logic [7:0] ctrl,
    output logic [7:0] gpo,
    output logic       irq
);

    localparam logic [7:0] ADDR_ID     = 8'h00;
    localparam logic [7:0] ADDR_CTRL   = 8'h01;
    localparam logic [7:0] ADDR_STATUS = 8'h02;
    localparam logic [7:0] ADDR_MASK   = 8'h03;
    localparam logic [7:0] ADDR_GPO    = 8'h04;
    localparam logic [7:0] ADDR_GPI    = 8'h05;
    localparam logic [7:0] ADDR_WRCNT  = 8'h06;
    localparam logic [7:0] ADDR_UNMAP  = 8'h10;

    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] irq_mask_q, irq_mask_d;
    logic [7:0] irq_status_q, irq_status_d;
    logic [7:0] gpo_q, gpo_d;
    logic [7:0] wr_count_q, wr_count_d;
    logic [7:0] rdata_q, rdata_d;
    logic       irq_q, irq_d;
    logic [7:0] scratch_q [8];
    logic [7:0] scratch_d [8];
    logic [6:0] irq_s1_q, irq_s1_d;
    logic [6:0] irq_s2_q, irq_s2_d;
    logic [6:0] irq_prev_q, irq_prev_d;
    logic [7:0] gpi_s1_q, gpi_s1_d;
    logic [7:0] gpi_s2_q, gpi_s2_d;

    logic       wr_acc;
    logic       is_scratch;
    logic [7:0] rd_addr;
    logic [7:0] rd_val;
    logic [7:0] st_set;
    logic [7:0] st_clr;

    assign is_scratch = (addr[7:3] == 5'b00001);

    always_comb begin
        rd_val = 8'h00;
        if (is_scratch) begin
            rd_val = scratch_q[addr[2:0]];
        end else begin
            case (addr)
                ADDR_ID:     rd_val = DEVICE_ID;
                ADDR_CTRL:   rd_val = ctrl_q;
                ADDR_STATUS: rd_val = irq_status_q;
                ADDR_MASK:   rd_val = irq_mask_q;
                ADDR_GPO:    rd_val = gpo_q;
                ADDR_GPI:    rd_val = gpi_s2_q;
                ADDR_WRCNT:  rd_val = wr_count_q;
                default:     rd_val = 8'h00;
            endcase
        end
    end

    always_comb begin
        ctrl_d       = ctrl_q;
        irq_mask_d   = irq_mask_q;
        gpo_d        = gpo_q;
        wr_count_d   = wr_count_q;
        scratch_d    = scratch_q;
        wr_acc       = wen & ~rw;
        // The slave has already advanced addr when it pulses rdata_used.
        rd_addr      = addr - 8'd1;
        st_set       = {1'b0, irq_s2_q & ~irq_prev_q};
        st_clr       = 8'h00;

        if (wr_acc) begin
            if (wr_count_q != 8'hFF) begin
                wr_count_d = wr_count_q + 8'd1;
            end
            if (is_scratch) begin
                scratch_d[addr[2:0]] = wdata;
            end else if (addr >= ADDR_UNMAP) begin
                st_set[7] = 1'b1;
            end else begin
                case (addr)
                    ADDR_CTRL:   ctrl_d     = wdata;
                    ADDR_STATUS: st_clr     = st_clr | wdata;
                    ADDR_MASK:   irq_mask_d = wdata;
                    ADDR_GPO:    gpo_d      = wdata;
                    default:     ;
                endcase
            end
        end

        // Read-clear only drops bits the slave actually captured, so events
        // arriving after rdata was registered stay pending.
        if (rdata_used) begin
            if (rd_addr == ADDR_STATUS) begin
                st_clr = st_clr | rdata_q;
            end
            if (rd_addr >= ADDR_UNMAP) begin
                st_set[7] = 1'b1;
            end
        end

        irq_status_d = (irq_status_q & ~st_clr) | st_set;
        irq_d        = |(irq_status_q & irq_mask_q);
        rdata_d      = rd_val;

        irq_s1_d     = irq_in;
        irq_s2_d     = irq_s1_q;
        irq_prev_d   = irq_s2_q;
        gpi_s1_d     = gpi;
        gpi_s2_d     = gpi_s1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q       <= CTRL_RESET;
            irq_mask_q   <= '0;
            irq_status_q <= '0;
            gpo_q        <= '0;
            wr_count_q   <= '0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                scratch_q[i] <= '0;
            end
            irq_s1_q     <= '0;
            irq_s2_q     <= '0;
            irq_prev_q   <= '0;
            gpi_s1_q     <= '0;
            gpi_s2_q     <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            irq_mask_q   <= irq_mask_d;
            irq_status_q <= irq_status_d;
            gpo_q        <= gpo_d;
            wr_count_q   <= wr_count_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
            scratch_q    <= scratch_d;
            irq_s1_q     <= irq_s1_d;
            irq_s2_q     <= irq_s2_d;
            irq_prev_q   <= irq_prev_d;
            gpi_s1_q     <= gpi_s1_d;
            gpi_s2_q     <= gpi_s2_d;
        end
    end

    assign rdata = rdata_q;
    assign ctrl  = ctrl_q;
    assign gpo   = gpo_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_i2c_regbank.sv
// Testbench for i2c_regbank: directed sequences, a write/readback table and
// randomized traffic, all compared against a cycle-level reference model.
module tb_i2c_regbank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       wen = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rdata_used = 1'b0;
    logic [6:0] irq_in = 7'h00;
    logic [7:0] gpi = 8'h00;
    logic [7:0] rdata;
    logic [7:0] ctrl;
    logic [7:0] gpo;
    logic       irq;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    i2c_regbank dut (
        .clk(clk), .rst(rst), .rw(rw), .addr(addr), .wen(wen), .wdata(wdata),
        .rdata_used(rdata_used), .rdata(rdata), .irq_in(irq_in), .gpi(gpi),
        .ctrl(ctrl), .gpo(gpo), .irq(irq)
    );

    initial forever #5 clk = ~clk;

    // Reference model: register map state plus input delay lines.
    typedef struct packed {
        logic [7:0]      ctrl;
        logic [7:0]      mask;
        logic [7:0]      gpo;
        logic [7:0]      status;
        logic [7:0]      cnt;
        logic [7:0][7:0] scr;
        logic [7:0]      rdata;
        logic            irq;
        logic [2:0][6:0] ih;   // [0] newest sample of irq_in
        logic [1:0][7:0] gh;   // [1] is the synchronized gpi
    } model_t;

    model_t m = '0;

    function automatic logic [7:0] mread(input model_t s, input logic [7:0] a);
        if (a >= 8'h08 && a <= 8'h0F) return s.scr[a[2:0]];
        case (a)
            8'h00: return 8'hA5;
            8'h01: return s.ctrl;
            8'h02: return s.status;
            8'h03: return s.mask;
            8'h04: return s.gpo;
            8'h05: return s.gh[1];
            8'h06: return s.cnt;
            default: return 8'h00;
        endcase
    endfunction

    function automatic model_t mstep(input model_t s, input logic r, input logic rw_i,
                                     input logic [7:0] a, input logic we, input logic [7:0] d,
                                     input logic used, input logic [6:0] ii, input logic [7:0] gi);
        model_t n = s;
        logic [7:0] set;
        logic [7:0] clr = 8'h00;
        logic [7:0] eff = a - 8'd1;
        if (!r) begin
            n = '0;
            return n;
        end
        set = {1'b0, s.ih[1] & ~s.ih[2]};
        if (we && !rw_i) begin
            n.cnt = (s.cnt == 8'hFF) ? 8'hFF : s.cnt + 8'd1;
            if (a >= 8'h08 && a <= 8'h0F) n.scr[a[2:0]] = d;
            else if (a >= 8'h10) set[7] = 1'b1;
            else if (a == 8'h01) n.ctrl = d;
            else if (a == 8'h02) clr = clr | d;
            else if (a == 8'h03) n.mask = d;
            else if (a == 8'h04) n.gpo = d;
        end
        if (used) begin
            if (eff == 8'h02) clr = clr | s.rdata;
            if (eff >= 8'h10) set[7] = 1'b1;
        end
        n.status = (s.status & ~clr) | set;
        n.irq = |(s.status & s.mask);
        n.rdata = mread(s, a);
        n.ih = {s.ih[1], s.ih[0], ii};
        n.gh = {s.gh[0], gi};
        return n;
    endfunction

    always @(posedge clk) m <= mstep(m, rst, rw, addr, wen, wdata, rdata_used, irq_in, gpi);

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("model_rdata", rdata, m.rdata);
            chk("model_ctrl", ctrl, m.ctrl);
            chk("model_gpo", gpo, m.gpo);
            chk("model_irq", {7'h0, irq}, {7'h0, m.irq});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        rw = 1'b0; addr = a; wdata = d; wen = 1'b1;
        step();
        wen = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        step();
        chk(name, rdata, exp);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{8'h01, 8'h5A, 8'h5A};
        tbl[1] = '{8'h00, 8'h12, 8'hA5};
        tbl[2] = '{8'h07, 8'hFF, 8'h00};
        tbl[3] = '{8'h03, 8'hF0, 8'hF0};
        tbl[4] = '{8'h06, 8'h00, 8'h05};
        tbl[5] = '{8'h20, 8'h33, 8'h00};
        tbl[6] = '{8'h09, 8'h77, 8'h77};
        tbl[7] = '{8'h0F, 8'hC3, 8'hC3};
        tbl[8] = '{8'h05, 8'hAA, 8'h00};

        // 1: reset state
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        chk_en = 1'b1;
        rdchk("reset_id", 8'h00, 8'hA5);
        rdchk("reset_ctrl_rd", 8'h01, 8'h00);
        chk("reset_ctrl", ctrl, 8'h00);
        chk("reset_gpo", gpo, 8'h00);
        chk("reset_irq", {7'h0, irq}, 8'h00);

        // 2: writes, RO write, rw=1 strobe
        wr(8'h04, 8'h3C);
        chk("gpo_write", gpo, 8'h3C);
        rdchk("wrcnt_1", 8'h06, 8'h01);
        wr(8'h00, 8'hFF);
        rdchk("id_ro", 8'h00, 8'hA5);
        rdchk("wrcnt_2", 8'h06, 8'h02);
        rw = 1'b1; addr = 8'h04; wdata = 8'h99; wen = 1'b1;
        step();
        wen = 1'b0; rw = 1'b0;
        chk("rw1_gpo", gpo, 8'h3C);
        rdchk("rw1_wrcnt", 8'h06, 8'h02);

        // 3: interrupt edge, mask, read-clear
        irq_in = 7'h04;
        step();
        irq_in = 7'h00;
        step(); step(); step();
        rdchk("irq_status_set", 8'h02, 8'h04);
        chk("irq_masked", {7'h0, irq}, 8'h00);
        wr(8'h03, 8'h04);
        step();
        chk("irq_unmasked", {7'h0, irq}, 8'h01);
        addr = 8'h02;
        step();
        chk("status_capture", rdata, 8'h04);
        addr = 8'h03; rdata_used = 1'b1;
        step();
        rdata_used = 1'b0;
        step();
        chk("irq_after_rdclr", {7'h0, irq}, 8'h00);
        rdchk("status_after_rdclr", 8'h02, 8'h00);

        // 4: set beats W1C in the same cycle
        irq_in = 7'h01;
        step(); step();
        wr(8'h02, 8'h01);
        rdchk("set_beats_w1c", 8'h02, 8'h01);
        wr(8'h02, 8'hFF);
        irq_in = 7'h00;
        rdchk("w1c_clear", 8'h02, 8'h00);

        // 5: scratch write and sequential readback, unmapped access
        for (int i = 0; i < 8; i++) wr(8'h08 + 8'(i), 8'h11 + 8'(i));
        addr = 8'h08;
        step();
        for (int i = 0; i < 8; i++) begin
            chk("scratch_seq", rdata, 8'h11 + 8'(i));
            addr = addr + 8'd1; rdata_used = 1'b1;
            step();
            rdata_used = 1'b0;
        end
        chk("unmapped_rd", rdata, 8'h00);
        rdchk("no_err_yet", 8'h02, 8'h00);
        addr = 8'h11; rdata_used = 1'b1;
        step();
        rdata_used = 1'b0;
        rdchk("unmapped_err", 8'h02, 8'h80);
        wr(8'h02, 8'h80);
        rdchk("wrcnt_14", 8'h06, 8'h0E);

        // 6: saturation, then reset mid-write with irq asserted
        for (int i = 0; i < 300; i++) wr(8'h07, 8'(i));
        rdchk("wrcnt_sat", 8'h06, 8'hFF);
        rdchk("reserved_rd", 8'h07, 8'h00);
        wr(8'h01, 8'h5A);
        irq_in = 7'h04;
        step();
        irq_in = 7'h00;
        step(); step(); step(); step();
        chk("irq_before_rst", {7'h0, irq}, 8'h01);
        addr = 8'h01; wdata = 8'h77; wen = 1'b1; rst = 1'b0;
        step();
        rst = 1'b1; wen = 1'b0;
        chk("rst_ctrl", ctrl, 8'h00);
        chk("rst_gpo", gpo, 8'h00);
        chk("rst_irq", {7'h0, irq}, 8'h00);
        for (int a = 0; a < 16; a++) rdchk("rst_reg", 8'(a), (a == 0) ? 8'hA5 : 8'h00);

        // Table: write then read back
        for (int i = 0; i < 9; i++) begin
            wr(tbl[i].a, tbl[i].d);
            rdchk("table", tbl[i].a, tbl[i].exp);
        end
        gpi = 8'h5A;
        step(); step(); step();
        rdchk("gpi_sync", 8'h05, 8'h5A);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = (($urandom % 250) != 0);
            rw = (($urandom % 4) == 0);
            addr = (($urandom % 8) == 0) ? 8'($urandom) : 8'($urandom_range(0, 18));
            wen = (($urandom % 3) == 0);
            wdata = 8'($urandom);
            rdata_used = (($urandom % 4) == 0);
            if (($urandom % 4) == 0) irq_in = irq_in ^ 7'($urandom);
            gpi = 8'($urandom);
            step();
        end
        rst = 1'b1; wen = 1'b0; rdata_used = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_regbank.md
Name: i2c_regbank

Overview:
- Register bank that consumes the application bus of the I2C slave (`rw`/`addr`/`wen`/`wdata`/`rdata_used`/`rdata`).
- Provides the device ID, a control byte, a sticky interrupt block, GPIO, a write counter and 8 bytes of scratch storage.
- Sits directly downstream of the I2C slave, in the same `clk` domain; no CDC on the bus side.
- Drives the chip-level control, GPO and IRQ outputs.

Parameters:
- `DEVICE_ID`, 8'hA5, value returned at address 0x00.
- `CTRL_RESET`, 8'h00, reset value of CTRL.

Ports:
- `clk`, input, 1, system clock.
- `rst`, input, 1, reset: synchronous, active-low.
- `rw`, input, 1, from slave; 1 = read transaction, 0 = write transaction.
- `addr`, input, 8, register address from slave.
- `wen`, input, 1, one-cycle write strobe; `addr`/`wdata` are valid in the same cycle.
- `wdata`, input, 8, write data.
- `rdata_used`, input, 1, one-cycle pulse: slave captured `rdata`. The slave has already incremented `addr` in this same cycle.
- `rdata`, output, 8, read data for current `addr`; registered.
- `irq_in`, input, 7, asynchronous interrupt sources; rising-edge sensitive.
- `gpi`, input, 8, asynchronous general inputs.
- `ctrl`, output, 8, CTRL register.
- `gpo`, output, 8, GPO register.
- `irq`, output, 1, registered interrupt request, active-high.

Behaviour:

Register map (addresses outside this map are unmapped):
- 0x00 ID: RO, `DEVICE_ID`.
- 0x01 CTRL: RW.
- 0x02 IRQ_STATUS: sticky bits, cleared by W1C or by read. Bits 6:0 = `irq_in` events; bit 7 = access to an unmapped address.
- 0x03 IRQ_MASK: RW.
- 0x04 GPO: RW.
- 0x05 GPI: RO, synchronized `gpi`.
- 0x06 WR_COUNT: RO, number of accepted writes, saturating at 0xFF.
- 0x07: RO 0x00, reserved. Writes are ignored and do not set the error bit.
- 0x08–0x0F: scratch RAM, RW.
- 0x10–0xFF: unmapped. Reads return 0x00, writes are ignored, and any access sets IRQ_STATUS[7].

Reset (`rst`=0 sampled at `clk` rising edge):
- CTRL = `CTRL_RESET`; all other registers, scratch, `rdata`, `gpo`, `irq` and synchronizers = 0.

Writes:
- Accepted when `wen`=1 and `rw`=0. `wen` with `rw`=1 is ignored entirely.
- The target register updates on the same edge; the corresponding output is visible the next cycle.
- An accepted write to any address (including RO, reserved or unmapped) increments WR_COUNT, saturating at 0xFF.
- A write to a RO address changes nothing except WR_COUNT.
- IRQ_STATUS write: bits written 1 clear, bits written 0 unchanged.

Reads:
- `rdata` <= decode(`addr`) every cycle, giving 1-cycle latency after any `addr` change.
- The slave samples `rdata` well after `addr` settles, so no stall is needed.

Read side effects (on `rdata_used`=1):
- Effective read address = (`addr` − 1) mod 256, because `addr` has already incremented.
- If effective address = 0x02: clear the IRQ_STATUS bits that were set in the `rdata` value captured at that pulse. Bits set after capture survive.
- If effective address ≥ 0x10: set IRQ_STATUS[7].

Interrupt inputs:
- `irq_in` and `gpi` each pass through a 2-flop synchronizer.
- A rising edge on a synchronized `irq_in[i]` (sync2=1, previous=0) sets IRQ_STATUS[i].

Priority on IRQ_STATUS bits:
- Set (edge or error) beats clear (W1C or read-clear) in the same cycle.

IRQ output:
- `irq` <= |(IRQ_STATUS & IRQ_MASK), registered: one cycle after the status/mask update.

WR_COUNT:
- 8-bit, saturating; it never wraps.

Simultaneous `wen` and `rdata_used`:
- Both are processed. When they act on the same IRQ_STATUS bit, the clear effects OR together, and set still wins.

Reset mid-transaction:
- All state returns to reset values on the next edge; no pending side effect survives.

Test Plan:
1. Reset, then `addr`=0x00 -> `rdata`=0xA5 after 1 cycle. `addr`=0x01 -> 0x00. `ctrl`=0x00, `gpo`=0x00, `irq`=0.
2. `wen` at `addr`=0x04 with `wdata`=0x3C -> `gpo`=0x3C next cycle and WR_COUNT=1. `wen` at 0x00 with 0xFF -> ID still 0xA5 and WR_COUNT=2. `wen` with `rw`=1 -> no change.
3. Pulse `irq_in[2]` high -> IRQ_STATUS=0x04 ≤3 cycles later, `irq`=0. Write IRQ_MASK=0x04 -> `irq`=1. Read-clear (`addr`=0x03 with `rdata_used`, i.e. effective 0x02) -> STATUS=0x00 and `irq`=0 next cycle.
4. Rising edge on `irq_in[0]` coincident with W1C write of 0x01 to 0x02 -> bit 0 remains 1 (set wins).
5. Write 0x11..0x18 to 0x08..0x0F, then read back sequentially with `rdata_used`/`addr` increments -> values match. Access 0x10 -> `rdata`=0x00 and IRQ_STATUS[7]=1.
6. Issue 300 writes -> WR_COUNT=0xFF (no wrap). Assert `rst`=0 mid-sequence -> every register returns to its reset value.
